// File: rtl/input_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// input_buffer_ctrl
//
// Flow-control front end for an input buffer built around an external
// synchronous RAM with a registered read port. Flits arrive on a valid/ready
// handshake, are written into the RAM, and are read out into a single output
// register slot (the RAM's read-data register) that feeds the downstream
// valid/ready handshake. There is no bypass path, so the minimum in-to-out
// latency is two cycles.
//
// Capacity is DEPTH flits in the RAM plus one flit held on out_data. `occupancy`
// counts only the flits still in the RAM.
//
// Optional feature (macro CREDIT_RETURN_EN):
//   defined   - credit_out pulses for one cycle after every downstream consume
//   undefined - credit_out is tied to 0
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset          : synchronous, active-high reset
//   in_valid       : upstream flit present
//   in_ready       : buffer can accept a flit this cycle (not full)
//   in_data        : upstream flit
//   out_valid      : out_data holds a valid flit
//   out_ready      : downstream consumes the flit this cycle
//   out_data       : downstream flit (RAM registered read data)
//   ram_write_en   : RAM write enable
//   ram_read_en    : RAM read enable
//   ram_write_addr : RAM write address
//   ram_read_addr  : RAM read address
//   ram_data_in    : RAM write data
//   ram_data_out   : RAM read data, valid one cycle after ram_read_en
//   occupancy      : flits in the RAM not yet read out (0..DEPTH)
//   credit_out     : one-cycle pulse per flit leaving the block
// -----------------------------------------------------------------------------
module input_buffer_ctrl #(
  parameter int DATA_WIDTH    = 100,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     ram_write_en,
  output logic                     ram_read_en,
  output logic [ADDRESS_WIDTH-1:0] ram_write_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out,
  output logic [ADDRESS_WIDTH:0]   occupancy,
  output logic                     credit_out
);

  // Occupancy value meaning "RAM full": DEPTH = 2**ADDRESS_WIDTH.
  localparam logic [ADDRESS_WIDTH:0] fullCount = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [ADDRESS_WIDTH-1:0] wrPtr;
  logic [ADDRESS_WIDTH-1:0] rdPtr;
  logic [ADDRESS_WIDTH:0]   occCount;
  logic                     outValidQ;
  logic                     writeFire;
  logic                     readFire;

  // in_ready depends only on state, never on in_valid, so upstream may wait
  // for it without creating a combinational loop.
  assign in_ready = (occCount != fullCount);

  // A read is issued whenever the RAM holds a flit and the output slot is
  // empty or being emptied this cycle; this gives 1 flit/cycle streaming.
  // Both enables are masked by reset so nothing reaches the RAM during reset.
  assign writeFire = in_valid & in_ready & ~reset;
  assign readFire  = (occCount != '0) & (~outValidQ | out_ready) & ~reset;

  // Reads need occCount != 0, so rdPtr != wrPtr unless the RAM is full, and a
  // full RAM blocks writes: the two ports never target the same address.
  assign ram_write_en   = writeFire;
  assign ram_read_en    = readFire;
  assign ram_write_addr = wrPtr;
  assign ram_read_addr  = rdPtr;
  assign ram_data_in    = in_data;

  assign out_valid = outValidQ;
  assign out_data  = ram_data_out;
  assign occupancy = occCount;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occCount  <= '0;
      outValidQ <= 1'b0;
    end else begin
      // Pointers wrap naturally modulo DEPTH through ADDRESS_WIDTH overflow.
      if (writeFire) wrPtr <= wrPtr + ADDRESS_WIDTH'(1);
      if (readFire)  rdPtr <= rdPtr + ADDRESS_WIDTH'(1);

      case ({writeFire, readFire})
        2'b10:   occCount <= occCount + (ADDRESS_WIDTH+1)'(1);
        2'b01:   occCount <= occCount - (ADDRESS_WIDTH+1)'(1);
        default: occCount <= occCount;
      endcase

      // A new read refills the output slot; otherwise a consume empties it.
      if (readFire)
        outValidQ <= 1'b1;
      else if (out_ready)
        outValidQ <= 1'b0;
    end
  end

`ifdef CREDIT_RETURN_EN
  logic creditQ;

  always_ff @(posedge clk) begin
    if (reset) creditQ <= 1'b0;
    else       creditQ <= outValidQ & out_ready;
  end

  assign credit_out = creditQ;
`else
  assign credit_out = 1'b0;
`endif

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_input_buffer_ctrl
//
// Self-checking bench for input_buffer_ctrl. Contains a registered-read RAM
// attached to the RAM ports and a queue-based reference model: the model holds
// the RAM contents as an ordered queue plus the single flit sitting on
// out_data, and every cycle derives the expected handshakes, enables,
// addresses, occupancy and credit from those. Directed sequences add literal
// expectations; randomized traffic (with occasional resets) exercises wrap,
// stalls and full/empty boundaries.
// -----------------------------------------------------------------------------
module tb_input_buffer_ctrl;

  localparam int DW    = 100;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          ram_write_en;
  logic          ram_read_en;
  logic [AW-1:0] ram_write_addr;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic [AW:0]   occupancy;
  logic          credit_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  input_buffer_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .ram_write_en   (ram_write_en),
    .ram_read_en    (ram_read_en),
    .ram_write_addr (ram_write_addr),
    .ram_read_addr  (ram_read_addr),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out),
    .occupancy      (occupancy),
    .credit_out     (credit_out)
  );

  // Storage RAM with a registered read port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_data_in;
    if (ram_read_en)  ram_data_out <= mem[ram_read_addr];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare (on the falling edge, inputs stable)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ramQ[$];
  logic          mValid  = 1'b0;
  logic [DW-1:0] mData   = '0;
  logic          mCredit = 1'b0;
  int unsigned   wrCnt   = 0;
  int unsigned   rdCnt   = 0;
  bit            started = 1'b0;

  always @(negedge clk) begin : compare
    bit expIn, wr, rd, cons;
    if (reset) begin
      check("wen_in_reset", ram_write_en, 1'b0);
      check("ren_in_reset", ram_read_en, 1'b0);
      ramQ.delete();
      mValid  = 1'b0;
      mCredit = 1'b0;
      wrCnt   = 0;
      rdCnt   = 0;
      started = 1'b1;
    end else if (started) begin
      expIn = (ramQ.size() != DEPTH);
      wr    = in_valid && expIn;
      rd    = (ramQ.size() != 0) && (!mValid || out_ready);
      cons  = mValid && out_ready;

      check("in_ready", in_ready, expIn);
      check("occupancy", occupancy, ramQ.size());
      check("out_valid", out_valid, mValid);
      if (mValid) check("out_data", out_data, mData);
      check("ram_write_en", ram_write_en, wr);
      check("ram_read_en", ram_read_en, rd);
      if (wr) begin
        check("ram_write_addr", ram_write_addr, wrCnt % DEPTH);
        check("ram_data_in", ram_data_in, in_data);
      end
      if (rd) check("ram_read_addr", ram_read_addr, rdCnt % DEPTH);
      if (wr && rd) check("addr_collision", ram_write_addr == ram_read_addr, 1'b0);
`ifdef CREDIT_RETURN_EN
      check("credit_out", credit_out, mCredit);
`else
      check("credit_out", credit_out, 1'b0);
`endif

      // Advance: read pops the oldest RAM flit into the output slot.
      if (rd) begin
        mData = ramQ.pop_front();
        rdCnt++;
      end
      if (wr) begin
        ramQ.push_back(in_data);
        wrCnt++;
      end
      if (rd)        mValid = 1'b1;
      else if (cons) mValid = 1'b0;
      mCredit = cons;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  task automatic drain(input string name, input bit randomReady);
    int n;
    n = 0;
    drive(1'b0, '0, 1'b1);
    while ((occupancy != 0 || out_valid) && n < 200) begin
      out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check({name, "_drained"}, n < 200, 1'b1);
  endtask

  initial begin : stim
    int seq, n, credits;
    logic [DW-1:0] one, two, three, dv;
    bit v, r;

    one = 1; two = 2; three = 3;

    // Reset state
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    check("rst_occupancy", occupancy, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_credit", credit_out, 1'b0);

    // Three back-to-back flits: out_valid two cycles after the first write.
    drive(1'b1, one, 1'b1);   tick();
    check("lat_ov_n1", out_valid, 1'b0);
    drive(1'b1, two, 1'b1);   tick();
    check("lat_ov_n2", out_valid, 1'b1);
    check("lat_d1", out_data, 1);
    drive(1'b1, three, 1'b1); tick();
    check("lat_d2", out_data, 2);
    drive(1'b0, '0, 1'b1);    tick();
    check("lat_d3", out_data, 3);
    tick();
    check("lat_ov_end", out_valid, 1'b0);

    // Fill with downstream stalled.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, rnd(), 1'b0);
      tick();
    end
    check("fill16_occ", occupancy, 15);
    check("fill16_ov", out_valid, 1'b1);
    check("fill16_in_ready", in_ready, 1'b1);
    drive(1'b1, rnd(), 1'b0); tick();
    check("fill17_occ", occupancy, 16);
    check("fill17_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rnd(), 1'b0);
      tick();
    end
    check("full_hold_occ", occupancy, 16);

    // One consume from full, then a simultaneous write and read.
    drive(1'b0, '0, 1'b1); tick();
    check("unfull_in_ready", in_ready, 1'b1);
    check("unfull_occ", occupancy, 15);
    drive(1'b1, rnd(), 1'b1); tick();
    check("wr_rd_occ", occupancy, 15);
    drain("after_full", 1'b0);

    // Credit pulses for five drained flits.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rnd(), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0); tick();
    credits = 0;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (credit_out) credits++;
    end
`ifdef CREDIT_RETURN_EN
    check("credit_count", credits, 5);
`else
    check("credit_count", credits, 0);
`endif

    // Ordered flits 0..39 with random valid/ready across pointer wrap.
    seq = 0;
    n   = 0;
    while (seq < 40 && n < 2000) begin
      v  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 2) != 0);
      dv = DW'(seq);
      drive(v, dv, r);
      if (v && in_ready) seq++;
      tick();
      n++;
    end
    check("seq40_sent", seq, 40);
    drain("seq40", 1'b1);

    // Reset mid-operation with occupancy 7 and a flit on out_data.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rnd(), 1'b0);
      tick();
    end
    check("pre_rst_occ", occupancy, 7);
    check("pre_rst_ov", out_valid, 1'b1);
    reset = 1'b1;
    drive(1'b1, rnd(), 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    check("post_rst_ov", out_valid, 1'b0);
    check("post_rst_occ", occupancy, 0);
    check("post_rst_in_ready", in_ready, 1'b1);
    repeat (5) tick();
    check("post_rst_no_stale", out_valid, 1'b0);

    // Random soak with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 3) != 0));
      tick();
    end
    reset = 1'b0;
    drain("soak", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
